// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fib_pkg
// Brief   : Shared types and constants for the Fibonacci generator/checker.
// Revision: 1.0 - initial release
// ============================================================================
package fib_pkg;

    localparam int FIB_DATA_WIDTH_DEFAULT = 32;
    localparam int FIB_CNT_WIDTH_DEFAULT  = 16;
    localparam int FIB_SEED               = 1;

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } fib_chk_state_t;

endpackage
`default_nettype wire

// File: rtl/fib_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : fib_sat_counter
// Brief   : Up-counter with synchronous clear and enable, holding at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
module fib_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fib_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : fib_stream_checker
// Brief   : Checks a Fibonacci term stream, counts terms, flags first error/wrap.
// Revision: 1.0 - initial release
// ============================================================================
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = FIB_DATA_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = FIB_CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  restart,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  chk_pulse,
    output logic [CNT_WIDTH-1:0]  term_idx,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  err_idx,
    output logic                  ovf,
    output logic [CNT_WIDTH-1:0]  ovf_idx
);

    fib_chk_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] prev1_q, prev1_d;
    logic [DATA_WIDTH-1:0] prev2_q, prev2_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;
    logic                  chk_pulse_q, chk_pulse_d;
    logic [CNT_WIDTH-1:0]  err_idx_q, err_idx_d;
    logic [CNT_WIDTH-1:0]  ovf_idx_q, ovf_idx_d;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] expected;
    logic                  checking;
    logic                  mismatch;
    logic [CNT_WIDTH-1:0]  term_idx_cnt;

    // Carry bit of the unreduced sum marks an arithmetic wrap.
    assign sum      = {1'b0, prev1_q} + {1'b0, prev2_q};
    assign expected = (state_q == RUN) ? sum[DATA_WIDTH-1:0] : DATA_WIDTH'(FIB_SEED);
    assign checking = in_valid && (state_q != ERR);
    assign mismatch = checking && (in_data != expected);

    fib_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_term_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (restart),
        .en     (checking),
        .count  (term_idx_cnt)
    );

    always_comb begin
        state_d     = state_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        err_d       = err_q;
        err_idx_d   = err_idx_q;
        ovf_d       = ovf_q;
        ovf_idx_d   = ovf_idx_q;
        chk_pulse_d = 1'b0;

        if (restart) begin
            state_d   = SEED0;
            prev1_d   = '0;
            prev2_d   = '0;
            err_d     = 1'b0;
            err_idx_d = '0;
            ovf_d     = 1'b0;
            ovf_idx_d = '0;
        end else if (checking) begin
            chk_pulse_d = 1'b1;
            case (state_q)
                SEED0: begin
                    prev2_d = in_data;
                    state_d = SEED1;
                end
                SEED1: begin
                    prev1_d = in_data;
                    state_d = RUN;
                end
                RUN: begin
                    prev2_d = prev1_q;
                    prev1_d = in_data;
                    // Only the first wrap is recorded, match or not.
                    if (sum[DATA_WIDTH] && !ovf_q) begin
                        ovf_d     = 1'b1;
                        ovf_idx_d = term_idx_cnt;
                    end
                end
                default: state_d = ERR;
            endcase
            if (mismatch) begin
                err_d     = 1'b1;
                err_idx_d = term_idx_cnt;
                state_d   = ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SEED0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
            ovf_q       <= 1'b0;
            ovf_idx_q   <= '0;
            chk_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
            ovf_q       <= ovf_d;
            ovf_idx_q   <= ovf_idx_d;
            chk_pulse_q <= chk_pulse_d;
        end
    end

    assign chk_pulse = chk_pulse_q;
    assign term_idx  = term_idx_cnt;
    assign err       = err_q;
    assign err_idx   = err_idx_q;
    assign ovf       = ovf_q;
    assign ovf_idx   = ovf_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_fib_stream_checker
// Brief   : Scoreboard bench; a 32/16 and an 8/4 checker run in lockstep.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fib_stream_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        restart;
    logic        in_valid;
    logic [31:0] in_data;

    logic        a_pulse, a_err, a_ovf;
    logic [15:0] a_idx, a_eidx, a_oidx;
    logic        b_pulse, b_err, b_ovf;
    logic [3:0]  b_idx, b_eidx, b_oidx;

    always #5 clk = ~clk;

    fib_stream_checker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .restart(restart), .in_valid(in_valid),
        .in_data(in_data), .chk_pulse(a_pulse), .term_idx(a_idx),
        .err(a_err), .err_idx(a_eidx), .ovf(a_ovf), .ovf_idx(a_oidx)
    );

    fib_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .resetn(resetn), .restart(restart), .in_valid(in_valid),
        .in_data(in_data[7:0]), .chk_pulse(b_pulse), .term_idx(b_idx),
        .err(b_err), .err_idx(b_eidx), .ovf(b_ovf), .ovf_idx(b_oidx)
    );

    typedef struct {
        longint pulse; longint idx; longint err; longint eidx; longint ovf; longint oidx;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     pulses_a     = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int     m_state[2];
    longint m_p1[2], m_p2[2], m_cnt[2], m_err[2], m_eidx[2], m_ovf[2], m_oidx[2], m_pulse[2];
    longint m_mask[2] = '{64'hFFFF_FFFF, 64'hFF};
    longint m_cmax[2] = '{65535, 15};

    task automatic check_val(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k, input bit clr, input bit v, input longint d);
        longint dm, s, ex;
        if (clr) begin
            m_state[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
            m_eidx[k] = 0; m_ovf[k] = 0; m_oidx[k] = 0; m_pulse[k] = 0;
        end else if (v && m_state[k] != 3) begin
            dm = d & m_mask[k];
            s  = m_p1[k] + m_p2[k];
            ex = (m_state[k] == 2) ? (s & m_mask[k]) : 1;
            if (m_state[k] == 2 && s > m_mask[k] && m_ovf[k] == 0) begin
                m_ovf[k] = 1; m_oidx[k] = m_cnt[k];
            end
            if (dm != ex) begin
                m_err[k] = 1; m_eidx[k] = m_cnt[k]; m_state[k] = 3;
            end else begin
                case (m_state[k])
                    0: begin m_p2[k] = dm; m_state[k] = 1; end
                    1: begin m_p1[k] = dm; m_state[k] = 2; end
                    default: begin m_p2[k] = m_p1[k]; m_p1[k] = dm; end
                endcase
            end
            m_pulse[k] = 1;
            if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        end else begin
            m_pulse[k] = 0;
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.pulse = m_pulse[k]; e.idx = m_cnt[k]; e.err = m_err[k];
        e.eidx = m_eidx[k]; e.ovf = m_ovf[k]; e.oidx = m_oidx[k];
        return e;
    endfunction

    task automatic cycle(input bit rn, input bit rs, input bit v, input logic [31:0] d);
        exp_t e;
        resetn = rn; restart = rs; in_valid = v; in_data = d;
        for (int k = 0; k < 2; k++) model_step(k, !rn || rs, v, longint'(d));
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
        @(posedge clk);
        #1;
        pulses_a += int'(a_pulse);
        e = q_a.pop_front();
        check_val("a.chk_pulse", a_pulse, e.pulse);
        check_val("a.term_idx",  a_idx,   e.idx);
        check_val("a.err",       a_err,   e.err);
        check_val("a.err_idx",   a_eidx,  e.eidx);
        check_val("a.ovf",       a_ovf,   e.ovf);
        check_val("a.ovf_idx",   a_oidx,  e.oidx);
        e = q_b.pop_front();
        check_val("b.chk_pulse", b_pulse, e.pulse);
        check_val("b.term_idx",  b_idx,   e.idx);
        check_val("b.err",       b_err,   e.err);
        check_val("b.err_idx",   b_eidx,  e.eidx);
        check_val("b.ovf",       b_ovf,   e.ovf);
        check_val("b.ovf_idx",   b_oidx,  e.oidx);
    endtask

    task automatic send(input logic [31:0] d);
        cycle(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_restart();
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic send_fib(input int n);
        logic [31:0] f0, f1, f2;
        f0 = 32'd1; f1 = 32'd1;
        for (int i = 0; i < n; i++) begin
            send(f0);
            f2 = f0 + f1; f0 = f1; f1 = f2;
        end
    endtask

    initial begin
        resetn = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0;
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'd99);
        check_val("reset.term_idx", a_idx, 0);
        check_val("reset.err",      a_err, 0);
        check_val("reset.pulse",    a_pulse, 0);

        // Clean stream
        pulses_a = 0;
        send(1); send(1); send(2); send(3); send(5); send(8);
        idle();
        check_val("clean.term_idx", a_idx, 6);
        check_val("clean.pulses",   pulses_a, 6);
        check_val("clean.err",      a_err, 0);
        check_val("clean.ovf",      a_ovf, 0);

        // Bad term
        do_restart();
        send(1); send(1); send(2); send(4);
        check_val("bad.err",     a_err, 1);
        check_val("bad.err_idx", a_eidx, 3);
        pulses_a = 0;
        send(5); idle();
        check_val("bad.term_idx", a_idx, 4);
        check_val("bad.pulses",   pulses_a, 0);

        // Wrap on the 8-bit checker
        do_restart();
        send_fib(15);
        check_val("wrap.ovf",     b_ovf, 1);
        check_val("wrap.ovf_idx", b_oidx, 13);
        check_val("wrap.err",     b_err, 0);

        // Restart mid-stream with a coincident valid term
        do_restart();
        send(1); send(1); send(2); send(7);
        check_val("rst.err_before", a_err, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'd1);
        check_val("rst.term_idx", a_idx, 0);
        check_val("rst.err",      a_err, 0);
        check_val("rst.err_idx",  a_eidx, 0);
        check_val("rst.pulse",    a_pulse, 0);
        send(1); send(1);
        check_val("rst.term_idx2", a_idx, 2);
        check_val("rst.err2",      a_err, 0);

        // Gaps
        do_restart();
        pulses_a = 0;
        send(1); idle(); send(1); idle(); idle(); send(2);
        check_val("gap.term_idx", a_idx, 3);
        check_val("gap.pulses",   pulses_a, 3);
        check_val("gap.err",      a_err, 0);

        // Saturation on the 4-bit counter
        do_restart();
        send_fib(20);
        check_val("sat.term_idx",   b_idx, 15);
        check_val("sat.ovf_idx",    b_oidx, 13);
        check_val("sat.err",        b_err, 0);
        check_val("sat.a_term_idx", a_idx, 20);
        send(32'd10946);
        check_val("sat.term_idx_hold", b_idx, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
